// File: rtl/crc_pkg.sv
// Shared types and the elaboration-time CRC table generator for the streaming CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    OUT  = 2'd2
  } state_e;

  // MSB-first CRC of one byte shifted through a zeroed register of the given width.
  function automatic logic [31:0] crc_table_entry(input logic [31:0] poly,
                                                  input int          width,
                                                  input logic [7:0]  b);
    logic [31:0] r;
    r = 32'(b) << (width - 8);
    for (int i = 0; i < 8; i++) begin
      if (r[width-1]) r = (r << 1) ^ poly;
      else            r = r << 1;
    end
    if (width < 32) r = r & ((32'd1 << width) - 32'd1);
    return r;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte CRC update through a 256-entry table generated at elaboration.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h07
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  output logic [CRC_W-1:0] crc_o
);

  typedef logic [255:0][CRC_W-1:0] table_t;

  function automatic table_t build_table();
    table_t t;
    for (int i = 0; i < 256; i++) begin
      t[i] = CRC_W'(crc_table_entry(32'(POLY), CRC_W, 8'(i)));
    end
    return t;
  endfunction

  localparam table_t TABLE = build_table();

  logic [7:0] tbl_idx;

  assign tbl_idx = crc_i[CRC_W-1 -: 8] ^ byte_i;
  // For CRC_W = 8 the shift leaves nothing, so only the table term remains.
  assign crc_o   = (crc_i << 8) ^ TABLE[tbl_idx];

endmodule

// File: rtl/crc_stream_engine.sv
// Framed byte-stream CRC engine: accepts a beat, walks its kept bytes one per clock,
// and presents the final CRC plus an expected-value match at frame end.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 'h07,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               BYTES   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*BYTES-1:0] s_data,
  input  logic [BYTES-1:0]   s_keep,
  input  logic               s_last,
  input  logic [CRC_W-1:0]   exp_crc,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CRC_W-1:0]   m_crc,
  output logic               m_match,
  output state_e             dbg_state
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Handshakes: a beat transfers on an edge where s_valid && s_ready; a result
  // transfers on an edge where m_valid && m_ready. Both ready/valid are registered.

  state_e               state_q, state_d;
  logic [CRC_W-1:0]     crc_q, crc_d;
  logic [8*BYTES-1:0]   data_q, data_d;
  logic [BYTES-1:0]     keep_q, keep_d;
  logic                 last_q, last_d;
  logic [CRC_W-1:0]     exp_q, exp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic [CRC_W-1:0]     m_crc_q, m_crc_d;
  logic                 m_match_q, m_match_d;

  logic [7:0]           cur_byte;
  logic                 nxt_keep;
  logic                 beat_done;
  logic [CRC_W-1:0]     step_crc;
  logic [CRC_W-1:0]     crc_post;
  logic [CRC_W-1:0]     result;
  logic                 enter_out;

  crc_byte_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_i  (crc_q),
    .byte_i (cur_byte),
    .crc_o  (step_crc)
  );

  always_comb begin
    cur_byte = '0;
    nxt_keep = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_byte = data_q[8*i +: 8];
        nxt_keep = (i < BYTES - 1) ? keep_q[(i + 1) % BYTES] : 1'b0;
      end
    end
    // A zero keep bit ends the beat even if higher bits are set.
    beat_done = (idx_q == IDX_W'(BYTES - 1)) || !nxt_keep;
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    exp_d     = exp_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_crc_d   = m_crc_q;
    m_match_d = m_match_q;
    crc_post  = crc_q;
    result    = '0;
    enter_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          data_d = s_data;
          keep_d = s_keep;
          last_d = s_last;
          idx_d  = '0;
          if (s_last) exp_d = exp_crc;
          if (s_keep[0]) begin
            state_d = PROC;
          end else if (s_last) begin
            state_d   = OUT;
            enter_out = 1'b1;
          end
        end
      end
      PROC: begin
        crc_d    = step_crc;
        crc_post = step_crc;
        if (beat_done) begin
          if (last_q) begin
            state_d   = OUT;
            enter_out = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (m_ready) begin
          crc_d     = INIT;
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_out) begin
      result    = crc_post ^ XOR_OUT;
      m_valid_d = 1'b1;
      m_crc_d   = result;
      m_match_d = (result == exp_d);
    end

    s_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      data_q    <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      exp_q     <= '0;
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_match_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      last_q    <= last_d;
      exp_q     <= exp_d;
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_crc_q   <= m_crc_d;
      m_match_q <= m_match_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_crc     = m_crc_q;
  assign m_match   = m_match_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: three BYTES=1 engines share one byte stream, a BYTES=4 engine has its own.
`timescale 1ns/1ps
module tb_crc_stream_engine;
  import crc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- group A: BYTES = 1 ----------------
  logic        a_valid, a_last, a_mready;
  logic [7:0]  a_data;
  logic [0:0]  a_keep;
  logic [7:0]  a_exp8;
  logic [15:0] a_exp16a, a_exp16b;

  logic        r8_sready, r8_mvalid, r8_match;
  logic [7:0]  r8_crc;
  state_e      r8_state;
  logic        r16a_sready, r16a_mvalid, r16a_match;
  logic [15:0] r16a_crc;
  state_e      r16a_state;
  logic        r16b_sready, r16b_mvalid, r16b_match;
  logic [15:0] r16b_crc;
  state_e      r16b_state;

  // ---------------- group B: BYTES = 4 ----------------
  logic        b_valid, b_last, b_mready;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic [15:0] b_exp;
  logic        rb_sready, rb_mvalid, rb_match;
  logic [15:0] rb_crc;
  state_e      rb_state;

  crc_stream_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .BYTES(1)) u_crc8 (
    .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(r8_sready), .s_data(a_data),
    .s_keep(a_keep), .s_last(a_last), .exp_crc(a_exp8), .m_valid(r8_mvalid), .m_ready(a_mready),
    .m_crc(r8_crc), .m_match(r8_match), .dbg_state(r8_state));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .BYTES(1)) u_crc16a (
    .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(r16a_sready), .s_data(a_data),
    .s_keep(a_keep), .s_last(a_last), .exp_crc(a_exp16a), .m_valid(r16a_mvalid), .m_ready(a_mready),
    .m_crc(r16a_crc), .m_match(r16a_match), .dbg_state(r16a_state));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .BYTES(1)) u_crc16b (
    .clk(clk), .rst_n(rst_n), .s_valid(a_valid), .s_ready(r16b_sready), .s_data(a_data),
    .s_keep(a_keep), .s_last(a_last), .exp_crc(a_exp16b), .m_valid(r16b_mvalid), .m_ready(a_mready),
    .m_crc(r16b_crc), .m_match(r16b_match), .dbg_state(r16b_state));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .BYTES(4)) u_crc16w (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(rb_sready), .s_data(b_data),
    .s_keep(b_keep), .s_last(b_last), .exp_crc(b_exp), .m_valid(rb_mvalid), .m_ready(b_mready),
    .m_crc(rb_crc), .m_match(rb_match), .dbg_state(rb_state));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Cycle accounting for the wide engine, sampled on the active edge before update.
  logic b_cnt_en = 1'b0;
  int   proc_cnt = 0;
  int   acc_cnt  = 0;
  always @(posedge clk) begin
    if (b_cnt_en) begin
      if (rb_state == PROC) proc_cnt++;
      if (b_valid && rb_sready) acc_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic a_beat(input logic [7:0] d, input logic k, input logic l);
    int n = 0;
    @(negedge clk);
    while (!r8_sready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_tmo", 32'(r8_sready), 32'd1);
    a_valid = 1'b1; a_data = d; a_keep = k; a_last = l;
    @(posedge clk); #1;
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic a_frame(input string s);
    for (int i = 0; i < s.len(); i++) a_beat(s[i], 1'b1, i == s.len() - 1);
  endtask

  task automatic a_wait_out(output int edges);
    edges = 0;
    while (!r8_mvalid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check("a_out_tmo", 32'(r8_mvalid), 32'd1);
  endtask

  task automatic a_ack();
    @(negedge clk);
    a_mready = 1'b1;
    @(posedge clk); #1;
    a_mready = 1'b0;
    check("a_ack_mvalid", 32'(r8_mvalid), 32'd0);
    check("a_ack_sready", 32'(r8_sready), 32'd1);
  endtask

  task automatic b_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    @(negedge clk);
    while (!rb_sready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_ready_tmo", 32'(rb_sready), 32'd1);
    b_valid = 1'b1; b_data = d; b_keep = k; b_last = l;
    @(posedge clk); #1;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic b_wait_out(output int edges);
    edges = 0;
    while (!rb_mvalid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b_out_tmo", 32'(rb_mvalid), 32'd1);
  endtask

  task automatic b_ack();
    @(negedge clk);
    b_mready = 1'b1;
    @(posedge clk); #1;
    b_mready = 1'b0;
    check("b_ack_mvalid", 32'(rb_mvalid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int    e;
    string digits;
    digits = "123456789";

    a_valid = 0; a_last = 0; a_mready = 0; a_data = '0; a_keep = '0;
    a_exp8 = 8'h00; a_exp16a = 16'h31C3; a_exp16b = 16'h29B1;
    b_valid = 0; b_last = 0; b_mready = 0; b_data = '0; b_keep = '0; b_exp = 16'h31C3;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sready",  32'(r8_sready), 32'd0);
    check("rst_mvalid",  32'(r8_mvalid), 32'd0);
    check("rst_mcrc",    32'(r8_crc),    32'd0);
    check("rst_match",   32'(r8_match),  32'd0);
    check("rst_state",   32'(r8_state),  32'(IDLE));
    check("rst_b_crc",   32'(rb_crc),    32'd0);
    check("rst_b_ready", 32'(rb_sready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-byte frames, table spot checks and latency.
    a_beat(8'h01, 1'b1, 1'b1);
    check("lat01_pre", 32'(r8_mvalid), 32'd0);
    a_wait_out(e);
    check("lat01", e, 1);
    check("crc8_01", 32'(r8_crc), 32'h07);
    check("crc16_01", 32'(r16a_crc), 32'h1021);
    a_ack();

    a_beat(8'hFF, 1'b1, 1'b1);
    a_wait_out(e);
    check("latff", e, 1);
    check("crc8_ff", 32'(r8_crc), 32'hF3);
    a_ack();

    // Check string, match on, then match off with a 10-cycle stall.
    a_exp8 = 8'hF4;
    a_frame(digits);
    a_wait_out(e);
    check("crc8_str", 32'(r8_crc), 32'hF4);
    check("crc8_match1", 32'(r8_match), 32'd1);
    check("xmodem_str", 32'(r16a_crc), 32'h31C3);
    check("xmodem_match", 32'(r16a_match), 32'd1);
    check("ccitt_str", 32'(r16b_crc), 32'h29B1);
    a_ack();

    a_exp8 = 8'hF5;
    a_frame(digits);
    a_wait_out(e);
    exp_q.push_back(32'hF4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_mvalid", 32'(r8_mvalid), 32'd1);
      check("hold_crc", 32'(r8_crc), exp_q[0]);
      check("hold_match0", 32'(r8_match), 32'd0);
      check("hold_sready", 32'(r8_sready), 32'd0);
    end
    void'(exp_q.pop_front());
    a_ack();

    // Empty frame: keep = 0 on a last beat.
    a_exp8 = 8'h00;
    a_beat(8'h5A, 1'b0, 1'b1);
    a_wait_out(e);
    check("empty16b", 32'(r16b_crc), 32'hFFFF);
    check("empty16a", 32'(r16a_crc), 32'h0000);
    check("empty8", 32'(r8_crc), 32'h00);
    check("empty8_match", 32'(r8_match), 32'd1);
    a_ack();

    // Dropped beat (keep = 0, not last) must not disturb the next frame.
    a_exp8 = 8'hF4;
    a_beat(8'hAA, 1'b0, 1'b0);
    check("drop_state", 32'(r8_state), 32'(IDLE));
    check("drop_mvalid", 32'(r8_mvalid), 32'd0);
    a_frame(digits);
    a_wait_out(e);
    check("drop_crc8", 32'(r8_crc), 32'hF4);
    a_ack();

    // Reset while the final byte is in PROC: no result, clean restart.
    for (int i = 0; i < 8; i++) a_beat(digits[i], 1'b1, 1'b0);
    a_beat(digits[8], 1'b1, 1'b1);
    check("abort_inproc", 32'(r8_state), 32'(PROC));
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(r8_state), 32'(IDLE));
    check("abort_sready", 32'(r8_sready), 32'd0);
    check("abort_mcrc", 32'(r16a_crc), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_mvalid", 32'(r8_mvalid), 32'd0);
    end
    a_frame(digits);
    a_wait_out(e);
    check("rerun_crc8", 32'(r8_crc), 32'hF4);
    check("rerun_match", 32'(r8_match), 32'd1);
    a_ack();

    // Wide engine: 1111, 1111, 0001 with cycle accounting.
    proc_cnt = 0; acc_cnt = 0; b_cnt_en = 1'b1;
    b_beat(32'h34333231, 4'b1111, 1'b0);
    b_beat(32'h38373635, 4'b1111, 1'b0);
    b_beat(32'h00000039, 4'b0001, 1'b1);
    b_wait_out(e);
    b_cnt_en = 1'b0;
    check("w_lat", e, 1);
    check("w_crc", 32'(rb_crc), 32'h31C3);
    check("w_match", 32'(rb_match), 32'd1);
    check("w_proc_cycles", proc_cnt, 9);
    check("w_accepts", acc_cnt, 3);
    b_ack();

    // Non-contiguous keep plus a leading dropped beat.
    b_beat(32'hDEADBEEF, 4'b0000, 1'b0);
    b_beat(32'h34333231, 4'b1111, 1'b0);
    b_beat(32'h38373635, 4'b1111, 1'b0);
    b_beat(32'h55AA1239, 4'b1101, 1'b1);
    b_wait_out(e);
    check("w_noncontig", 32'(rb_crc), 32'h31C3);
    b_ack();

    // Three-byte partial beats.
    b_beat(32'hEE333231, 4'b0111, 1'b0);
    b_beat(32'hEE363534, 4'b0111, 1'b0);
    b_beat(32'hEE393837, 4'b0111, 1'b1);
    b_wait_out(e);
    check("w_partial", 32'(rb_crc), 32'h31C3);
    b_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
